// File: rtl/pipeline_sequencer.sv
// Channel sweep sequencer: each selected channel runs ACQ -> FFT -> FE -> NN -> STORE into a result table.
// Optional per-stage watchdog is compiled in when SEQ_WATCHDOG_EN is defined.
module pipeline_sequencer #(
    parameter int  NUM_CH      = 4,
    parameter int  TIMEOUT_CYC = 4096,
    localparam int CW          = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              continuous,
    input  logic              sweep_go,
    output logic              acq_start,
    output logic [CW-1:0]     acq_ch,
    input  logic              acq_done,
    output logic              fft_start,
    input  logic              fft_done,
    output logic              fe_start,
    input  logic              fe_done,
    output logic              nn_start,
    input  logic              nn_done,
    input  logic [1:0]        class_id,
    input  logic [7:0]        confidence,
    input  logic [CW-1:0]     rd_ch,
    output logic [1:0]        rd_class,
    output logic [7:0]        rd_conf,
    output logic              res_valid,
    output logic              sweep_done,
    output logic              busy,
    output logic              timeout_err
);

    if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("pipeline_sequencer: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEL   = 3'd1,
        S_ACQ   = 3'd2,
        S_FFT   = 3'd3,
        S_FE    = 3'd4,
        S_NN    = 3'd5,
        S_STORE = 3'd6
    } state_t;

    state_t                   state_q, state_d;
    logic [CW:0]              ptr_q, ptr_d;
    logic [CW-1:0]            acq_ch_q, acq_ch_d;
    logic [1:0]               hold_class_q, hold_class_d;
    logic [7:0]               hold_conf_q, hold_conf_d;
    logic [NUM_CH-1:0][1:0]   res_class_q, res_class_d;
    logic [NUM_CH-1:0][7:0]   res_conf_q, res_conf_d;
    logic                     acq_start_q, acq_start_d;
    logic                     fft_start_q, fft_start_d;
    logic                     fe_start_q, fe_start_d;
    logic                     nn_start_q, nn_start_d;
    logic                     res_valid_q, res_valid_d;
    logic                     sweep_done_q, sweep_done_d;
    logic                     busy_q, busy_d;

    logic                     start_ok_s;
    logic                     in_stage_s;
    logic                     timeout_s;
    logic                     found_s;
    logic [CW-1:0]            found_idx_s;
    logic [CW:0]              next_ptr_s;

    assign start_ok_s = (state_q == S_IDLE) && sweep_go && enable && (ch_mask != '0);
    assign in_stage_s = (state_q == S_ACQ) || (state_q == S_FFT) || (state_q == S_FE) || (state_q == S_NN);
    assign next_ptr_s = {1'b0, acq_ch_q} + (CW+1)'(1);

    // Lowest enabled channel at or above the scan pointer (downward scan, last hit wins).
    always_comb begin
        found_s     = 1'b0;
        found_idx_s = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            found_idx_s = (ch_mask[i] && (i >= int'(ptr_q))) ? CW'(i) : found_idx_s;
            found_s     = found_s | (ch_mask[i] && (i >= int'(ptr_q)));
        end
    end

    // Next-state, scan pointer, result table and output pulse computation.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        acq_ch_d     = acq_ch_q;
        hold_class_d = hold_class_q;
        hold_conf_d  = hold_conf_q;
        res_class_d  = res_class_q;
        res_conf_d   = res_conf_q;
        sweep_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok_s) begin
                    ptr_d   = '0;
                    state_d = S_SEL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEL: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (found_s) begin
                    acq_ch_d = found_idx_s;
                    state_d  = S_ACQ;
                end else begin
                    sweep_done_d = 1'b1;
                    ptr_d        = '0;
                    state_d      = continuous ? S_SEL : S_IDLE;
                end
            end
            S_ACQ: begin
                if (acq_done) begin
                    state_d = S_FFT;
                end else if (timeout_s) begin
                    ptr_d   = next_ptr_s;
                    state_d = S_SEL;
                end else begin
                    state_d = S_ACQ;
                end
            end
            S_FFT: begin
                if (fft_done) begin
                    state_d = S_FE;
                end else if (timeout_s) begin
                    ptr_d   = next_ptr_s;
                    state_d = S_SEL;
                end else begin
                    state_d = S_FFT;
                end
            end
            S_FE: begin
                if (fe_done) begin
                    state_d = S_NN;
                end else if (timeout_s) begin
                    ptr_d   = next_ptr_s;
                    state_d = S_SEL;
                end else begin
                    state_d = S_FE;
                end
            end
            S_NN: begin
                if (nn_done) begin
                    hold_class_d = class_id;
                    hold_conf_d  = confidence;
                    state_d      = S_STORE;
                end else if (timeout_s) begin
                    ptr_d   = next_ptr_s;
                    state_d = S_SEL;
                end else begin
                    state_d = S_NN;
                end
            end
            S_STORE: begin
                res_class_d[acq_ch_q] = hold_class_q;
                res_conf_d[acq_ch_q]  = hold_conf_q;
                ptr_d                 = next_ptr_s;
                state_d               = enable ? S_SEL : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Start pulses mark only the first cycle spent in each stage.
        acq_start_d = (state_d == S_ACQ) && (state_q != S_ACQ);
        fft_start_d = (state_d == S_FFT) && (state_q != S_FFT);
        fe_start_d  = (state_d == S_FE)  && (state_q != S_FE);
        nn_start_d  = (state_d == S_NN)  && (state_q != S_NN);
        res_valid_d = (state_d == S_STORE);
        busy_d      = (state_d != S_IDLE);
    end

    // Main state and output register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            acq_ch_q     <= '0;
            hold_class_q <= 2'd0;
            hold_conf_q  <= 8'd0;
            res_class_q  <= '0;
            res_conf_q   <= '0;
            acq_start_q  <= 1'b0;
            fft_start_q  <= 1'b0;
            fe_start_q   <= 1'b0;
            nn_start_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            sweep_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            acq_ch_q     <= acq_ch_d;
            hold_class_q <= hold_class_d;
            hold_conf_q  <= hold_conf_d;
            res_class_q  <= res_class_d;
            res_conf_q   <= res_conf_d;
            acq_start_q  <= acq_start_d;
            fft_start_q  <= fft_start_d;
            fe_start_q   <= fe_start_d;
            nn_start_q   <= nn_start_d;
            res_valid_q  <= res_valid_d;
            sweep_done_q <= sweep_done_d;
            busy_q       <= busy_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          timeout_err_q, timeout_err_d;
    logic          stage_done_s;

    // Stage watchdog: counter restarts whenever a stage is left, so each stage entry starts at zero.
    always_comb begin
        case (state_q)
            S_ACQ:   stage_done_s = acq_done;
            S_FFT:   stage_done_s = fft_done;
            S_FE:    stage_done_s = fe_done;
            S_NN:    stage_done_s = nn_done;
            default: stage_done_s = 1'b0;
        endcase
        timeout_s = in_stage_s && !stage_done_s && (wd_q == WW'(TIMEOUT_CYC - 1));
        if (!in_stage_s || stage_done_s || timeout_s) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + WW'(1);
        end
        if (start_ok_s) begin
            timeout_err_d = 1'b0;
        end else if (timeout_s) begin
            timeout_err_d = 1'b1;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_s   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Readback from the registered table; selects beyond NUM_CH read as zero.
    always_comb begin
        if (int'(rd_ch) < NUM_CH) begin
            rd_class = res_class_q[rd_ch];
            rd_conf  = res_conf_q[rd_ch];
        end else begin
            rd_class = 2'd0;
            rd_conf  = 8'd0;
        end
    end

    assign acq_start  = acq_start_q;
    assign fft_start  = fft_start_q;
    assign fe_start   = fe_start_q;
    assign nn_start   = nn_start_q;
    assign res_valid  = res_valid_q;
    assign sweep_done = sweep_done_q;
    assign busy       = busy_q;
    assign acq_ch     = acq_ch_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: stage responder, result scoreboard and table model.
module tb_pipeline_sequencer;

    localparam int NUM_CH = 4;
    localparam int CW     = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic              continuous = 1'b0;
    logic              sweep_go = 1'b0;
    logic              acq_start, fft_start, fe_start, nn_start;
    logic [CW-1:0]     acq_ch;
    logic              acq_done = 1'b0, fft_done = 1'b0, fe_done = 1'b0, nn_done = 1'b0;
    logic [1:0]        class_id = 2'd0;
    logic [7:0]        confidence = 8'd0;
    logic [CW-1:0]     rd_ch = '0;
    logic [1:0]        rd_class;
    logic [7:0]        rd_conf;
    logic              res_valid, sweep_done, busy, timeout_err;

    pipeline_sequencer #(.NUM_CH(NUM_CH), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask), .continuous(continuous),
        .sweep_go(sweep_go), .acq_start(acq_start), .acq_ch(acq_ch), .acq_done(acq_done),
        .fft_start(fft_start), .fft_done(fft_done), .fe_start(fe_start), .fe_done(fe_done),
        .nn_start(nn_start), .nn_done(nn_done), .class_id(class_id), .confidence(confidence),
        .rd_ch(rd_ch), .rd_class(rd_class), .rd_conf(rd_conf), .res_valid(res_valid),
        .sweep_done(sweep_done), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int sb[$];
    logic [1:0] exp_class[NUM_CH];
    logic [7:0] exp_conf[NUM_CH];
    int res_cnt = 0, sweep_cnt = 0, sweep_target = 0;

    // responder controls
    bit         resp_en = 1'b0;
    bit         hold_en = 1'b0;
    int         hold_ch = 0;
    logic [1:0] resp_class = 2'd0;
    logic [7:0] resp_conf = 8'd0;
    int         inject_seq = 0, inject_which = 0;
    int         inj_seen = 0, stage_k = 0, cnt = 0, exp_next = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stage responder: done 3 cycles after each start, plus one-shot injected done pulses.
    always @(negedge clk) begin
        acq_done = 1'b0; fft_done = 1'b0; fe_done = 1'b0; nn_done = 1'b0;
        if (rst) begin
            cnt = 0; exp_next = 0;
        end else begin
            case (exp_next)
                2: chk("lat_fft_start", fft_start, 1);
                3: chk("lat_fe_start", fe_start, 1);
                4: chk("lat_nn_start", nn_start, 1);
                5: chk("lat_res_valid", res_valid, 1);
                default: ;
            endcase
            exp_next = 0;
            if (resp_en && cnt > 0) begin
                cnt--;
                if (cnt == 0 && !(stage_k == 3 && hold_en && int'(acq_ch) == hold_ch)) begin
                    case (stage_k)
                        1: acq_done = 1'b1;
                        2: fft_done = 1'b1;
                        3: fe_done = 1'b1;
                        default: begin nn_done = 1'b1; class_id = resp_class; confidence = resp_conf; end
                    endcase
                    exp_next = stage_k + 1;
                end
            end
            if (resp_en) begin
                if (acq_start) begin stage_k = 1; cnt = 3; end
                else if (fft_start) begin stage_k = 2; cnt = 3; end
                else if (fe_start) begin stage_k = 3; cnt = 3; end
                else if (nn_start) begin stage_k = 4; cnt = 3; end
            end
        end
        if (inject_seq != inj_seen) begin
            inj_seen = inject_seq;
            case (inject_which)
                1: acq_done = 1'b1;
                2: fft_done = 1'b1;
                3: fe_done = 1'b1;
                default: begin nn_done = 1'b1; class_id = 2'd3; confidence = 8'hFF; end
            endcase
        end
    end

    // Result monitor: every res_valid must match the oldest expected channel.
    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid) begin
                res_cnt++;
                if (sb.size() == 0) chk("res_valid_unexpected", res_valid, 0);
                else chk("res_ch", acq_ch, sb.pop_front());
            end
            if (sweep_done) sweep_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic inject(input int which);
        inject_which = which;
        inject_seq++;
    endtask

    task automatic pulse_go();
        sweep_go = 1'b1;
        tick(1);
        sweep_go = 1'b0;
    endtask

    // which: 0 acq_start, 1 fft_start, 2 fe_start, 3 sweep target reached, 4 idle
    task automatic wait_until(input int which, input int maxc, input string tag);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < maxc && !hit; k++) begin
            tick(1);
            case (which)
                0: hit = acq_start;
                1: hit = fft_start;
                2: hit = fe_start;
                3: hit = (sweep_cnt >= sweep_target);
                default: hit = !busy;
            endcase
        end
        chk(tag, hit, 1);
    endtask

    task automatic check_table(input string tag);
        for (int c = 0; c < NUM_CH; c++) begin
            rd_ch = CW'(c);
            tick(1);
            chk($sformatf("%s_class%0d", tag, c), rd_class, exp_class[c]);
            chk($sformatf("%s_conf%0d", tag, c), rd_conf, exp_conf[c]);
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < NUM_CH; c++) begin exp_class[c] = 2'd0; exp_conf[c] = 8'd0; end
    endtask

    initial begin
        int r0, s0;
        clear_model();
        tick(3);
        chk("reset_outputs", {acq_start, fft_start, fe_start, nn_start, res_valid, sweep_done, busy, timeout_err}, 0);
        chk("reset_acq_ch", acq_ch, 0);
        check_table("reset_tbl");
        rst = 1'b0;
        tick(1);
        chk("post_reset_pulses", {acq_start, fft_start, fe_start, nn_start, busy}, 0);

        // Ignored start requests: empty mask, then enable low.
        enable = 1'b1; ch_mask = 4'b0000;
        pulse_go(); tick(2);
        chk("go_mask0_busy", busy, 0);
        enable = 1'b0; ch_mask = 4'b1010;
        pulse_go(); tick(2);
        chk("go_dis_busy", busy, 0);
        chk("go_ignored_sweeps", sweep_cnt, 0);

        // Single sweep over channels 1 and 3.
        enable = 1'b1; resp_en = 1'b1; resp_class = 2'd2; resp_conf = 8'h80;
        sb.push_back(1); sb.push_back(3);
        exp_class[1] = 2'd2; exp_conf[1] = 8'h80; exp_class[3] = 2'd2; exp_conf[3] = 8'h80;
        r0 = res_cnt; s0 = sweep_cnt; sweep_target = s0 + 1;
        pulse_go();
        wait_until(3, 200, "sweep1_done_seen");
        tick(2);
        chk("sweep1_res_count", res_cnt - r0, 2);
        chk("sweep1_sweep_count", sweep_cnt - s0, 1);
        chk("sweep1_idle", busy, 0);
        chk("sweep1_sb_empty", sb.size(), 0);
        check_table("sweep1_tbl");

        // Continuous channel 0, then drop enable during FFT of the third pass.
        continuous = 1'b1; ch_mask = 4'b0001; resp_class = 2'd1; resp_conf = 8'h33;
        sb.push_back(0); sb.push_back(0); sb.push_back(0);
        exp_class[0] = 2'd1; exp_conf[0] = 8'h33;
        r0 = res_cnt; s0 = sweep_cnt; sweep_target = s0 + 2;
        pulse_go();
        wait_until(3, 400, "cont_two_sweeps_seen");
        wait_until(1, 50, "cont_third_fft_seen");
        enable = 1'b0;
        wait_until(4, 50, "cont_stop_idle");
        tick(4);
        chk("cont_res_count", res_cnt - r0, 3);
        chk("cont_sweep_count", sweep_cnt - s0, 2);
        chk("cont_sb_empty", sb.size(), 0);
        chk("cont_busy", busy, 0);
        check_table("cont_tbl");
        enable = 1'b1; continuous = 1'b0;

        // Stray nn_done during FFT, then reset two cycles after fft_start.
        resp_en = 1'b0; ch_mask = 4'b0100;
        r0 = res_cnt;
        pulse_go();
        wait_until(0, 10, "man_acq_start_seen");
        inject(1);
        wait_until(1, 10, "man_fft_start_seen");
        inject(4);
        tick(1);
        chk("stray_nn_busy_f1", busy, 1);
        tick(1);
        chk("stray_nn_busy_f2", busy, 1);
        chk("stray_nn_no_res", res_cnt - r0, 0);
        rst = 1'b1;
        tick(1);
        chk("midrst_outputs", {acq_start, fft_start, fe_start, nn_start, res_valid, sweep_done, busy, timeout_err}, 0);
        chk("midrst_acq_ch", acq_ch, 0);
        rst = 1'b0;
        tick(1);
        chk("midrst_release_pulses", {acq_start, fft_start, fe_start, nn_start, busy}, 0);
        inject(2);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("stray_fft_no_fe", {fe_start, busy}, 0);
        end
        clear_model();
        check_table("midrst_tbl");

`ifdef SEQ_WATCHDOG_EN
        // FE withheld on channel 0: watchdog skips it, channel 1 proceeds.
        resp_en = 1'b1; hold_en = 1'b1; hold_ch = 0; ch_mask = 4'b0011;
        resp_class = 2'd3; resp_conf = 8'h5A;
        sb.push_back(1);
        exp_class[1] = 2'd3; exp_conf[1] = 8'h5A;
        r0 = res_cnt; s0 = sweep_cnt; sweep_target = s0 + 1;
        pulse_go();
        wait_until(2, 100, "wd_fe_start_seen");
        chk("wd_fe_ch", acq_ch, 0);
        tick(15);
        chk("wd_err_before", timeout_err, 0);
        tick(1);
        chk("wd_err_at_limit", timeout_err, 1);
        wait_until(3, 200, "wd_sweep_seen");
        tick(2);
        chk("wd_res_count", res_cnt - r0, 1);
        chk("wd_sb_empty", sb.size(), 0);
        chk("wd_err_sticky", timeout_err, 1);
        check_table("wd_tbl");
        hold_en = 1'b0;
        sb.push_back(0); sb.push_back(1);
        exp_class[0] = 2'd3; exp_conf[0] = 8'h5A;
        sweep_target = sweep_cnt + 1;
        pulse_go();
        chk("wd_err_cleared", timeout_err, 0);
        wait_until(3, 200, "wd_resweep_seen");
        tick(2);
        chk("wd_resweep_sb_empty", sb.size(), 0);
        check_table("wd_resweep_tbl");
`else
        chk("no_wd_err", timeout_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
